// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scanning display multiplexer.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage : scan_mux_pkg

// File: rtl/scan_mux_tick.sv
// Dwell prescaler: counts clk cycles while running and pulses on the last one.
module scan_tick #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count;

    // Pulse in the cycle the dwell ends so the channel advances on that edge.
    assign tick = run && (count == LAST);

    // Dwell counter: cleared on entry/direct, frozen while not running.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

endmodule : scan_tick

// File: rtl/scan_mux.sv
// Registered N-channel mux with direct select and prescaled round-robin scan.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int unsigned WIDTH    = 4,
    parameter  int unsigned CHANNELS = 8,
    parameter  int unsigned PRESCALE = 16,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [SEL_W-1:0]          S,
    input  logic                      G,
    input  logic                      MODE,
    output logic [WIDTH-1:0]          Y,
    output logic [SEL_W-1:0]          CH,
    output logic [CHANNELS-1:0]       EN_OH,
    output logic                      WRAP
);

    state_t            state, state_nxt;
    logic              last_scan, last_scan_nxt;
    logic [SEL_W-1:0]  ch_nxt;
    logic              wrap_nxt;
    logic              tick_clr, tick_run, tick;
    logic              s_valid, resume;
    logic [WIDTH-1:0]  y_pick;
    logic [CHANNELS-1:0] en_pick;
    logic [WIDTH-1:0]  d_ch [CHANNELS];

    // Unpack the flat data bus into per-channel words.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign d_ch[k] = D[k*WIDTH +: WIDTH];
    end

    assign s_valid = 32'(S) < CHANNELS;
    // Continue an interrupted scan only if scanning was the last active mode.
    assign resume  = (state == SCAN) || ((state == BLANK) && last_scan);

    scan_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .run   (tick_run),
        .tick  (tick)
    );

    // State register and all output flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BLANK;
            last_scan <= 1'b0;
            CH        <= '0;
            Y         <= '0;
            EN_OH     <= '0;
            WRAP      <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_scan <= last_scan_nxt;
            CH        <= ch_nxt;
            Y         <= y_pick;
            EN_OH     <= en_pick;
            WRAP      <= wrap_nxt;
        end
    end

    // Next state, next channel and prescaler control.
    always_comb begin
        state_nxt     = BLANK;
        last_scan_nxt = last_scan;
        ch_nxt        = CH;
        wrap_nxt      = 1'b0;
        tick_clr      = 1'b0;
        tick_run      = 1'b0;

        if (G) begin
            state_nxt = BLANK;
        end else if (MODE == MODE_DIRECT) begin
            state_nxt = DIRECT;
        end else begin
            state_nxt = SCAN;
        end

        case (state_nxt)
            DIRECT: begin
                last_scan_nxt = 1'b0;
                tick_clr      = 1'b1;
                ch_nxt        = S;
            end
            SCAN: begin
                last_scan_nxt = 1'b1;
                if (!resume) begin
                    tick_clr = 1'b1;
                    ch_nxt   = s_valid ? S : '0;
                end else begin
                    tick_run = 1'b1;
                    if (tick) begin
                        if (CH == SEL_W'(CHANNELS - 1)) begin
                            ch_nxt   = '0;
                            wrap_nxt = 1'b1;
                        end else begin
                            ch_nxt = CH + SEL_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Data and digit enable for the channel being loaded; zero when blanked or out of range.
    always_comb begin
        y_pick  = '0;
        en_pick = '0;
        if (state_nxt != BLANK) begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                if (SEL_W'(k) == ch_nxt) begin
                    y_pick     = d_ch[k];
                    en_pick[k] = 1'b1;
                end
            end
        end
    end

endmodule : scan_mux

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: 8-channel/prescale-4 and 5-channel/prescale-1 instances.
module tb_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_g, a_mode;
    logic [31:0] a_d;
    logic [2:0]  a_s;
    logic [3:0]  a_y;
    logic [2:0]  a_ch;
    logic [7:0]  a_en;
    logic        a_wrap;

    logic        b_reset, b_g, b_mode;
    logic [19:0] b_d;
    logic [2:0]  b_s;
    logic [3:0]  b_y;
    logic [2:0]  b_ch;
    logic [4:0]  b_en;
    logic        b_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    scan_mux #(.WIDTH(4), .CHANNELS(8), .PRESCALE(4)) dut_a (
        .clk(clk), .reset(a_reset), .D(a_d), .S(a_s), .G(a_g), .MODE(a_mode),
        .Y(a_y), .CH(a_ch), .EN_OH(a_en), .WRAP(a_wrap)
    );

    scan_mux #(.WIDTH(4), .CHANNELS(5), .PRESCALE(1)) dut_b (
        .clk(clk), .reset(b_reset), .D(b_d), .S(b_s), .G(b_g), .MODE(b_mode),
        .Y(b_y), .CH(b_ch), .EN_OH(b_en), .WRAP(b_wrap)
    );

    typedef struct {
        int ch;
        int cnt;
        bit last;
        int y;
        int en;
        bit wrap;
        bit valid;
    } mst_t;

    mst_t ma = '{default: 0};
    mst_t mb = '{default: 0};

    // One clock of the behaviour described in terms of channels, dwell counts and last mode.
    function automatic mst_t mstep(mst_t m, int nch, int ps, logic rst, logic [31:0] d,
                                   int s, logic g, logic mode);
        mst_t r;
        r = m;
        if (rst) begin
            r = '{default: 0};
            r.valid = 1'b1;
        end else if (g) begin
            r.y = 0;
            r.en = 0;
            r.wrap = 1'b0;
        end else if (!mode) begin
            r.last = 1'b0;
            r.cnt = 0;
            r.wrap = 1'b0;
            r.ch = s;
            if (s < nch) begin
                r.y = int'((d >> (4 * s)) & 32'hF);
                r.en = 1 << s;
            end else begin
                r.y = 0;
                r.en = 0;
            end
        end else begin
            r.wrap = 1'b0;
            if (!m.last) begin
                r.ch = (s < nch) ? s : 0;
                r.cnt = 0;
            end else if (m.cnt == ps - 1) begin
                r.cnt = 0;
                if (m.ch == nch - 1) begin
                    r.ch = 0;
                    r.wrap = 1'b1;
                end else begin
                    r.ch = m.ch + 1;
                end
            end else begin
                r.cnt = m.cnt + 1;
            end
            r.last = 1'b1;
            r.y = int'((d >> (4 * r.ch)) & 32'hF);
            r.en = 1 << r.ch;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance both models on the same edge the DUTs sample.
    always @(posedge clk) begin
        ma <= mstep(ma, 8, 4, a_reset, a_d, int'(a_s), a_g, a_mode);
        mb <= mstep(mb, 5, 1, b_reset, {12'd0, b_d}, int'(b_s), b_g, b_mode);
    end

    // Every-cycle comparison of both instances against their models.
    always @(negedge clk) begin
        if (ma.valid) begin
            chk("a_y_model",    int'(a_y),    ma.y);
            chk("a_ch_model",   int'(a_ch),   ma.ch);
            chk("a_en_model",   int'(a_en),   ma.en);
            chk("a_wrap_model", int'(a_wrap), int'(ma.wrap));
        end
        if (mb.valid) begin
            chk("b_y_model",    int'(b_y),    mb.y);
            chk("b_ch_model",   int'(b_ch),   mb.ch);
            chk("b_en_model",   int'(b_en),   mb.en);
            chk("b_wrap_model", int'(b_wrap), int'(mb.wrap));
        end
    end

    initial begin
        a_reset = 1'b1; a_g = 1'b0; a_mode = 1'b1; a_s = 3'd3; a_d = 32'h7654_3210;
        b_reset = 1'b1; b_g = 1'b1; b_mode = 1'b0; b_s = 3'd0; b_d = 20'h4_3210;

        // Reset held with scan requested
        cyc(1);
        chk("rst_ch", int'(a_ch), 0);
        chk("rst_y",  int'(a_y),  0);
        cyc(1);
        chk("rst_en",   int'(a_en),   0);
        chk("rst_wrap", int'(a_wrap), 0);

        // Direct select
        a_reset = 1'b0; a_mode = 1'b0; a_s = 3'd5;
        cyc(1);
        chk("dir_y5",  int'(a_y),  5);
        chk("dir_ch5", int'(a_ch), 5);
        chk("dir_en5", int'(a_en), 8'h20);
        a_s = 3'd2;
        cyc(1);
        chk("dir_y2",  int'(a_y),  2);
        chk("dir_en2", int'(a_en), 8'h04);
        a_d = 32'h7654_3A10;
        cyc(1);
        chk("dir_live_d", int'(a_y), 10);

        // Scan from 6 with wrap
        a_s = 3'd6; a_mode = 1'b1;
        cyc(1);
        chk("scan_ch6", int'(a_ch), 6);
        chk("scan_y6",  int'(a_y),  6);
        chk("scan_en6", int'(a_en), 8'h40);
        chk("scan_nowrap_load", int'(a_wrap), 0);
        cyc(3);
        chk("scan_ch6_hold", int'(a_ch), 6);
        cyc(1);
        chk("scan_ch7", int'(a_ch), 7);
        chk("scan_y7",  int'(a_y),  7);
        cyc(3);
        chk("scan_ch7_hold", int'(a_ch), 7);
        cyc(1);
        chk("wrap_ch0",  int'(a_ch),   0);
        chk("wrap_set",  int'(a_wrap), 1);
        chk("wrap_en0",  int'(a_en),   1);
        cyc(1);
        chk("wrap_pulse_end", int'(a_wrap), 0);

        // Blank mid-dwell at CH=3 count=2, then resume
        cyc(13);
        chk("pre_blank_ch3", int'(a_ch), 3);
        a_g = 1'b1;
        cyc(5);
        chk("blank_y",  int'(a_y),  0);
        chk("blank_en", int'(a_en), 0);
        chk("blank_ch", int'(a_ch), 3);
        a_g = 1'b0;
        cyc(1);
        chk("resume_ch3", int'(a_ch), 3);
        chk("resume_y3",  int'(a_y),  3);
        cyc(1);
        chk("resume_ch4", int'(a_ch), 4);

        // Mode toggled mid-dwell
        cyc(1);
        a_mode = 1'b0; a_s = 3'd1;
        cyc(1);
        chk("toggle_dir_ch1", int'(a_ch), 1);
        a_mode = 1'b1; a_s = 3'd5;
        cyc(1);
        chk("reentry_ch5", int'(a_ch), 5);
        cyc(3);
        chk("reentry_hold5", int'(a_ch), 5);
        cyc(1);
        chk("reentry_ch6", int'(a_ch), 6);

        // G wins over a simultaneous mode change; scan resumes afterwards
        a_g = 1'b1; a_mode = 1'b0;
        cyc(1);
        chk("prio_y",  int'(a_y),  0);
        chk("prio_en", int'(a_en), 0);
        a_g = 1'b0; a_mode = 1'b1;
        cyc(1);
        chk("prio_resume_ch6", int'(a_ch), 6);

        // Reset mid-dwell with G toggling
        a_reset = 1'b1;
        cyc(1);
        chk("rst2_ch", int'(a_ch), 0);
        chk("rst2_y",  int'(a_y),  0);
        a_g = 1'b1;
        cyc(1);
        a_g = 1'b0;
        cyc(1);
        chk("rst2_en", int'(a_en), 0);
        a_reset = 1'b0; a_s = 3'd2;
        cyc(1);
        chk("rst2_restart_ch", int'(a_ch), 2);
        chk("rst2_restart_y",  int'(a_y),  10);
        chk("rst2_restart_en", int'(a_en), 8'h04);
        a_g = 1'b1;

        // Five channels, prescale 1
        b_reset = 1'b0; b_g = 1'b0; b_mode = 1'b0; b_s = 3'd6;
        cyc(1);
        chk("np2_y_oor",  int'(b_y),  0);
        chk("np2_en_oor", int'(b_en), 0);
        chk("np2_ch_oor", int'(b_ch), 6);
        b_s = 3'd3;
        cyc(1);
        chk("np2_y3",  int'(b_y),  3);
        chk("np2_en3", int'(b_en), 5'h08);
        b_mode = 1'b1; b_s = 3'd4;
        cyc(1);
        chk("np2_scan_ch4", int'(b_ch), 4);
        chk("np2_scan_y4",  int'(b_y),  4);
        chk("np2_scan_en4", int'(b_en), 5'h10);
        cyc(1);
        chk("np2_wrap_ch0", int'(b_ch),   0);
        chk("np2_wrap",     int'(b_wrap), 1);
        cyc(1);
        chk("np2_ch1",     int'(b_ch),   1);
        chk("np2_nowrap",  int'(b_wrap), 0);
        b_mode = 1'b0;
        cyc(1);
        b_mode = 1'b1; b_s = 3'd7;
        cyc(1);
        chk("np2_oor_entry_ch0", int'(b_ch),   0);
        chk("np2_oor_entry_nw",  int'(b_wrap), 0);
        cyc(1);
        chk("np2_after_entry_ch1", int'(b_ch), 1);

        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_scan_mux
